// File: rtl/keyed_xfer_fsm.sv
// Beat-counting transfer sequencer with a key lock; a wrong key lets the
// transfer run only until TRAP_BEATS beats have been accepted, then parks in TRAP.
module keyed_xfer_fsm #(
  parameter int                 CNT_W      = 8,
  parameter int                 KEY_W      = 4,
  parameter logic [KEY_W-1:0]   KEY_VAL    = 4'b1011,
  parameter int                 TRAP_BEATS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             ack,
  input  logic [KEY_W-1:0] keyinput,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  // state  | meaning
  // IDLE   | waiting for start with a non-zero len
  // REQ    | one-cycle request announce; key sampled on exit
  // XFER   | accepting beats, key matched
  // XFER_D | accepting beats, key mismatched; traps after TRAP_BEATS beats
  // DONE   | one-cycle completion pulse
  // TRAP   | locked out until reset
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    XFER   = 3'd2,
    XFER_D = 3'd3,
    DONE   = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRAP_CMP = CNT_W'(TRAP_BEATS);

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] dcnt_nxt;

  assign cnt_nxt  = cnt + ONE;
  assign dcnt_nxt = dcnt + ONE;

  // All state and outputs move on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      dcnt  <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && (len != '0)) begin
            len_q <= len;
            cnt   <= '0;
            dcnt  <= '0;
            state <= REQ;
            req   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          req   <= 1'b1;
          busy  <= 1'b1;
          done  <= 1'b0;
          state <= (keyinput == KEY_VAL) ? XFER : XFER_D;
        end
        XFER: begin
          if (ack) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state <= DONE;
              req   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        XFER_D: begin
          if (ack) begin
            cnt  <= cnt_nxt;
            dcnt <= dcnt_nxt;
            // Trap wins even when this beat would also complete the transfer.
            if (dcnt_nxt == TRAP_CMP) begin
              state <= TRAP;
              req   <= 1'b0;
              busy  <= 1'b1;
            end else if (cnt_nxt == len_q) begin
              state <= DONE;
              req   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        TRAP: begin
          req  <= 1'b0;
          busy <= 1'b1;
          done <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keyed_xfer_fsm.sv
// Directed bench for keyed_xfer_fsm; a monitor scores each done pulse or
// TRAP entry against an expected-response queue filled by the stimulus.
module tb_keyed_xfer_fsm;

  localparam logic [3:0] KEY_OK  = 4'b1011;
  localparam logic [3:0] KEY_BAD = 4'b0000;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       ack;
  logic [3:0] keyinput;
  logic       req;
  logic       busy;
  logic       done;
  logic [7:0] cnt;

  typedef struct {
    int trap;
    int cnt;
    int reqc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_err      = 0;
  int   resp_cnt   = 0;
  int   req_cycles = 0;
  bit   in_trap    = 0;

  keyed_xfer_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .ack      (ack),
    .keyinput (keyinput),
    .req      (req),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int trap, input int c, input int r);
    exp_t e;
    e.trap = trap;
    e.cnt  = c;
    e.reqc = r;
    exp_q.push_back(e);
  endtask

  task automatic start_xfer(input int l, input logic [3:0] k);
    @(posedge clk);
    start    = 1'b1;
    len      = 8'(l);
    keyinput = k;
    @(posedge clk);
    start = 1'b0;
  endtask

  task automatic wait_resp(input int target, input string name);
    int i;
    i = 0;
    while (resp_cnt < target && i < 60) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({name, "_resp_seen"}, int'(resp_cnt >= target), 1);
  endtask

  task automatic chk_outs(input string name, input int r, input int b, input int d, input int c);
    chk({name, "_req"},  int'(req),  r);
    chk({name, "_busy"}, int'(busy), b);
    chk({name, "_done"}, int'(done), d);
    chk({name, "_cnt"},  int'(cnt),  c);
  endtask

  // Monitor: sampled on the rising edge, half a cycle away from DUT updates.
  always @(posedge clk) begin
    if (rst) begin
      if (req) req_cycles++;
      if (done || (busy && !req && !in_trap)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: got done=%0d cnt=%0d expected no response", done, cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_trap", int'(busy && !req), e.trap);
          chk("resp_cnt",  int'(cnt),          e.cnt);
          chk("resp_reqc", req_cycles,         e.reqc);
        end
        resp_cnt++;
        req_cycles = 0;
      end
      in_trap = busy && !req;
    end
  end

  always @(negedge rst) req_cycles = 0;

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    len      = '0;
    ack      = 1'b0;
    keyinput = KEY_OK;
    #3;
    chk_outs("reset", 0, 0, 0, 0);
    #4;
    rst = 1'b1;

    // Correct key, len=3: REQ + 3 beats of req, then done with cnt=3
    push_exp(0, 3, 4);
    ack = 1'b1;
    start_xfer(3, KEY_OK);
    wait_resp(1, "ok_len3");
    @(posedge clk);
    #1;
    chk_outs("ok_len3_after", 0, 0, 0, 3);

    // Wrong key but only one beat: completes before the trap count
    push_exp(0, 1, 2);
    start_xfer(1, KEY_BAD);
    wait_resp(2, "bad_len1");

    // start with len=0 is ignored
    ack = 1'b0;
    start_xfer(0, KEY_OK);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("len0_busy", int'(busy), 0);
      chk("len0_req",  int'(req),  0);
    end

    // start pulsed during XFER must not disturb len_q or cnt
    push_exp(0, 3, 5);
    start_xfer(3, KEY_OK);
    @(posedge clk);
    start = 1'b1;
    len   = 8'd7;
    @(posedge clk);
    start = 1'b0;
    ack   = 1'b1;
    #1;
    chk("mid_start_cnt", int'(cnt), 0);
    chk("mid_start_req", int'(req), 1);
    wait_resp(3, "mid_start");

    // Stall after beat 1 plus a key change: cnt holds, transfer completes
    push_exp(0, 4, 8);
    start_xfer(4, KEY_OK);
    @(posedge clk);
    @(posedge clk);
    ack      = 1'b0;
    keyinput = KEY_BAD;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_cnt", int'(cnt), 1);
    end
    ack = 1'b1;
    wait_resp(4, "stall");

    // Wrong key, len=5: traps after 2 beats and stays there
    push_exp(1, 2, 3);
    start_xfer(5, KEY_BAD);
    wait_resp(5, "trap");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (i == 5) begin
        start = 1'b1;
        len   = 8'd3;
      end
      if (i == 6) start = 1'b0;
      #1;
      chk_outs("trap_hold", 0, 1, 0, 2);
    end
    #1;
    rst = 1'b0;
    #1;
    chk_outs("trap_reset", 0, 0, 0, 0);
    rst = 1'b1;

    // Reset in XFER with cnt=2 clears outputs immediately
    ack = 1'b1;
    start_xfer(5, KEY_OK);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_cnt", int'(cnt), 2);
    #1;
    rst = 1'b0;
    #1;
    chk_outs("xfer_reset", 0, 0, 0, 0);
    ack = 1'b0;
    #1;
    rst = 1'b1;

    // Operation resumes normally after reset
    push_exp(0, 2, 3);
    ack = 1'b1;
    start_xfer(2, KEY_OK);
    wait_resp(6, "resume");

    ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
